// File: rtl/param_reset_tree_pipeline.sv
// Replicated cubic-polynomial lanes whose valid chains are reset from a registered reset tree.
// Build option RESET_TREE_EN: when undefined, the root register drives every lane directly.
module param_reset_tree_pipeline #(
    parameter int WIDTH            = 8,
    parameter int NUM_REPLICATIONS = 8,
    parameter int FANOUT           = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       en,
    input  logic                                       valid_in,
    input  logic [NUM_REPLICATIONS-1:0][WIDTH-1:0]     in,
    output logic [NUM_REPLICATIONS-1:0][4*WIDTH-1:0]   out,
    output logic                                       valid_out,
    output logic                                       ready
);

    if (NUM_REPLICATIONS < 1 || FANOUT < 2) begin : g_param_check
        $fatal(1, "param_reset_tree_pipeline: NUM_REPLICATIONS must be >=1 and FANOUT >=2");
    end

`ifdef RESET_TREE_EN
    function automatic int calc_levels(input int n, input int f);
        int     k;
        longint p;
        k = 0;
        p = 1;
        if (f < 2) return 1;
        while (p < longint'(n)) begin
            p = p * f;
            k++;
        end
        return (k < 1) ? 1 : k;
    endfunction

    localparam int LEVELS = calc_levels(NUM_REPLICATIONS, FANOUT);

    // Nodes at tree level lvl (1..LEVELS); the last level holds one leaf per lane.
    function automatic int nodes_at(input int lvl);
        int p;
        p = 1;
        for (int j = lvl; j < LEVELS; j++) p = p * FANOUT;
        return (NUM_REPLICATIONS + p - 1) / p;
    endfunction

    function automatic int offset_at(input int lvl);
        int s;
        s = 0;
        for (int j = 1; j < lvl; j++) s += nodes_at(j);
        return s;
    endfunction

    localparam int N_NODES = offset_at(LEVELS + 1);
`else
    localparam int LEVELS = 0;
`endif

    localparam int RST_LATENCY = LEVELS + 1;
    localparam int LATENCY     = 4;
    localparam int RW          = 4 * WIDTH;
    localparam int CW          = $clog2(RST_LATENCY + 1);

    logic                        root_q;
    logic [CW-1:0]               cnt_q;
    logic [NUM_REPLICATIONS-1:0] lane_rst_n;
    logic [NUM_REPLICATIONS-1:0] lane_vld4;

    always_ff @(posedge clk) begin
        root_q <= rst_n;
    end

    // Saturates at RST_LATENCY: by then every leaf has seen the released root.
    always_ff @(posedge clk) begin
        if (!root_q) begin
            cnt_q <= '0;
        end else if (cnt_q != CW'(RST_LATENCY)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign ready = root_q && (cnt_q == CW'(RST_LATENCY));

`ifdef RESET_TREE_EN
    logic [N_NODES-1:0] node_q;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        for (genvar j = 0; j < nodes_at(l); j++) begin : g_node
            localparam int IDX = offset_at(l) + j;
            if (l == 1) begin : g_top
                always_ff @(posedge clk) node_q[IDX] <= root_q;
            end else begin : g_inner
                localparam int PAR = offset_at(l - 1) + j / FANOUT;
                always_ff @(posedge clk) node_q[IDX] <= node_q[PAR];
            end
        end
    end

    assign lane_rst_n = node_q[N_NODES-1 -: NUM_REPLICATIONS];
`else
    assign lane_rst_n = {NUM_REPLICATIONS{root_q}};
`endif

    for (genvar i = 0; i < NUM_REPLICATIONS; i++) begin : g_lane
        logic [RW-1:0]      x1, x2, sq2, x3, sq3, cu3, res4;
        logic [LATENCY-1:0] vld;

        always_ff @(posedge clk) begin
            if (en) begin
                x1   <= RW'(in[i]);
                x2   <= x1;
                sq2  <= x1 * x1;
                x3   <= x2;
                sq3  <= sq2;
                cu3  <= sq2 * x2;
                res4 <= RW'(10) * cu3 + RW'(20) * sq3 + RW'(30) * x3 + RW'(40);
            end
        end

        always_ff @(posedge clk) begin
            if (!lane_rst_n[i]) begin
                vld <= '0;
            end else if (en) begin
                vld <= {vld[LATENCY-2:0], valid_in & ready};
            end
        end

        assign out[i]       = res4;
        assign lane_vld4[i] = vld[LATENCY-1];
    end

    // Lanes share valid_in, en and equal-depth leaves, so this AND equals lane 0's flag.
    assign valid_out = (&lane_vld4) & ready;

endmodule
